mem_io_responder: RTL

//  Responder end of the CPU byte-wide memory bus: answers memctrl requests (cpu_a/cpu_wr/cpu_wdata).

---
 rtl/mem_io_responder_pkg.sv | 24 ++
 rtl/mem_io_responder_byte_fifo.sv | 55 +++++
 rtl/mem_io_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared decode constants and bus payload type for the memory/I-O responder.
package mem_io_responder_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ADDR_BUS = 32;
    localparam int unsigned DECODE_W = 18;

    localparam logic [1:0]          IO_PAGE      = 2'b11;
    localparam logic [DECODE_W-1:0] IO_UART_ADDR = 18'h30000;
    localparam logic [DECODE_W-1:0] IO_CLK_ADDR  = 18'h30004;

    // One request on the CPU byte bus.
    typedef struct packed {
        logic [ADDR_BUS-1:0] a;
        logic                wr;
        logic [BYTE_W-1:0]   wdata;
    } byte_bus_t;

    // True when the address falls in the I/O page.
    function automatic logic is_io_page(input logic [ADDR_BUS-1:0] a);
        return a[17:16] == IO_PAGE;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// 8-bit synchronous FIFO; head is visible whenever not empty, no write-through bypass.
module mem_io_responder_byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: RAM, host RX/TX FIFOs, cycle counter and halt flag.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned TX_DEPTH   = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [ADDR_BUS-1:0] cpu_a,
    input  logic                cpu_wr,
    input  logic [BYTE_W-1:0]   cpu_wdata,
    output logic [BYTE_W-1:0]   cpu_rdata,
    output logic                rdy_out,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                halt_o
);

    localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = 32;

    byte_bus_t          req;
    logic [BYTE_W-1:0]  ram [RAM_BYTES];
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   snapshot;
    logic               rx_live;
    logic               is_io;
    logic               is_uart;
    logic               is_clk;
    logic               is_clk_grp;
    logic               accept;
    logic               rd_acc;
    logic               wr_acc;
    logic               ram_we;
    logic [BYTE_W-1:0]  rd_next;
    logic               rx_push;
    logic               rx_pop;
    logic [BYTE_W-1:0]  rx_head;
    logic               rx_full;
    logic               rx_empty;
    logic               tx_push;
    logic [BYTE_W-1:0]  tx_push_data;
    logic               tx_full;
    logic               tx_empty;
    logic               unused_addr_hi;

    assign req            = '{a: cpu_a, wr: cpu_wr, wdata: cpu_wdata};
    assign unused_addr_hi = ^req.a[ADDR_BUS-1:DECODE_W];

    assign is_io      = is_io_page(req.a);
    assign is_uart    = (req.a[DECODE_W-1:0] == IO_UART_ADDR);
    assign is_clk     = (req.a[DECODE_W-1:0] == IO_CLK_ADDR);
    assign is_clk_grp = (req.a[DECODE_W-1:2] == IO_CLK_ADDR[DECODE_W-1:2]);

    // Stall only the UART byte port when its FIFO cannot take or supply a byte.
    assign rdy_out = !(is_uart && ((!req.wr && rx_empty) || (req.wr && tx_full)));

    assign accept = rst_in && rdy_out;
    assign rd_acc = accept && !req.wr;
    assign wr_acc = accept && req.wr;
    assign ram_we = wr_acc && !is_io;

    assign rx_ready = rx_live && !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd_acc && is_uart;

    // Halt writes push a zero terminator; zero bytes on the UART port are dropped.
    assign tx_push      = wr_acc && ((is_uart && (req.wdata != '0)) || is_clk);
    assign tx_push_data = is_clk ? '0 : req.wdata;
    assign tx_valid     = !tx_empty;

    // Read-data source select for the accepted read.
    always_comb begin
        rd_next = '0;
        if (!is_io) begin
            rd_next = ram[req.a[ADDR_WIDTH-1:0]];
        end else if (is_uart) begin
            rd_next = rx_head;
        end else if (is_clk_grp) begin
            case (req.a[1:0])
                2'd0:    rd_next = counter[7:0];
                2'd1:    rd_next = snapshot[15:8];
                2'd2:    rd_next = snapshot[23:16];
                default: rd_next = snapshot[31:24];
            endcase
        end
    end

    // RAM write port, contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[req.a[ADDR_WIDTH-1:0]] <= req.wdata;
    end

    // Read data, cycle counter, coherent snapshot, halt and RX enable.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cpu_rdata <= '0;
            counter   <= '0;
            snapshot  <= '0;
            halt_o    <= 1'b0;
            rx_live   <= 1'b0;
        end else begin
            counter <= counter + CNT_W'(1);
            rx_live <= 1'b1;
            if (rd_acc) begin
                cpu_rdata <= rd_next;
                if (is_clk) snapshot <= counter;
            end
            if (wr_acc && is_clk) halt_o <= 1'b1;
        end
    end

    mem_io_responder_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    mem_io_responder_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_valid && tx_ready),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

endmodule
